// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   DEFAULT_DATA_WIDTH : default operand/result width
//   alu_op_e           : ALU control codes understood by the shared ALU
//   arb_state_e        : arbiter FSM states
//   is_legal_op()      : true for codes the shared ALU implements
package alu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SLT = 4'b0101,
    OP_SRL = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BGE = 4'b1000,
    OP_XOR = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic is_legal_op(input logic [3:0] code);
    return code <= 4'b1001;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester request/response bundle between the requesters and the arbiter.
//   req_valid/req_ready : per-requester request handshake (bit i = requester i)
//   req_op1/req_op2     : per-requester operands
//   req_ctrl            : per-requester ALU control code
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_data/eq/err     : shared response payload
// master = requester side, slave = arbiter side.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0][DATA_WIDTH-1:0] req_op1;
  logic [1:0][DATA_WIDTH-1:0] req_op2;
  logic [1:0][3:0]            req_ctrl;
  logic [1:0]                 rsp_valid;
  logic [1:0]                 rsp_ready;
  logic [DATA_WIDTH-1:0]      rsp_data;
  logic                       rsp_eq;
  logic                       rsp_err;

  modport master (
    output req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_eq, rsp_err
  );

  modport slave (
    input  req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_eq, rsp_err
  );

endinterface

// File: rtl/alu.sv
// Shared combinational ALU used alongside the arbiter.
//   op1, op2 : operands
//   ctrl     : control code (alu_op_e); unknown codes give result 0
//   result   : operation result
//   eq       : op1 == op2
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [3:0]            ctrl,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = op2[SHW-1:0];
  assign eq    = (op1 == op2);

  // NOTE: combinational blocks assign every output first so no path can infer a latch.
  always_comb begin
    result = '0;
    case (alu_op_e'(ctrl))
      OP_ADD: result = op1 + op2;
      OP_SUB: result = op1 - op2;
      OP_AND: result = op1 & op2;
      OP_OR:  result = op1 | op2;
      OP_SLL: result = op1 << shamt;
      OP_SLT: result[0] = $signed(op1) < $signed(op2);
      OP_SRL: result = op1 >> shamt;
      OP_SRA: result = $signed(op1) >>> shamt;
      OP_BGE: result[0] = $signed(op1) >= $signed(op2);
      OP_XOR: result = op1 ^ op2;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin picker (purely combinational).
//   valid : request valid per requester
//   ptr   : preferred requester when both are valid
//   grant : one-hot grant, 00 when nothing is valid
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // A lone requester wins regardless of the pointer.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU, one
// transaction in flight: IDLE (grant + capture) -> EXEC (drive ALU,
// register result) -> RESP (hold response until the granted requester
// accepts it).
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus                 : request/response bundle (slave side)
//   alu_op1/op2/ctrl    : operands and code to the shared ALU (0 outside EXEC)
//   alu_result, alu_eq  : combinational return from the shared ALU
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_arbiter_if.slave          bus,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_eq
);

  arb_state_e            state_q, state_d;
  logic                  ptr_q;
  logic [1:0]            pick;
  logic                  sel;
  logic [1:0]            grant_q;
  logic [DATA_WIDTH-1:0] op1_q, op2_q;
  logic [3:0]            ctrl_q;
  logic                  legal_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  eq_q, err_q;
  logic                  rsp_done;

  rr_arb2 u_arb (
    .valid (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick)
  );

  assign sel      = pick[1];
  assign rsp_done = |(bus.rsp_ready & grant_q);

  assign bus.rsp_data = res_q;
  assign bus.rsp_eq   = eq_q;
  assign bus.rsp_err  = err_q;

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    alu_op1       = '0;
    alu_op2       = '0;
    alu_ctrl      = 4'b0000;
    unique case (state_q)
      IDLE: begin
        // rst_n gating keeps req_ready at 00 while reset is held.
        if (rst_n && (|bus.req_valid)) begin
          bus.req_ready = pick;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        // Illegal codes still flow through EXEC but present a neutral ALU input.
        if (legal_q) begin
          alu_op1  = op1_q;
          alu_op2  = op2_q;
          alu_ctrl = ctrl_q;
        end
        state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = grant_q;
        if (rsp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the payload/result registers are reset too, so the response bus reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 2'b00;
      op1_q   <= '0;
      op2_q   <= '0;
      ctrl_q  <= 4'b0000;
      legal_q <= 1'b0;
      res_q   <= '0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (|bus.req_valid) begin
            grant_q <= pick;
            op1_q   <= bus.req_op1[sel];
            op2_q   <= bus.req_op2[sel];
            ctrl_q  <= bus.req_ctrl[sel];
            legal_q <= is_legal_op(bus.req_ctrl[sel]);
          end
        end
        EXEC: begin
          res_q <= legal_q ? alu_result : '0;
          eq_q  <= legal_q & alu_eq;
          err_q <= ~legal_q;
        end
        RESP: begin
          // Prefer the other requester next time: after requester 0, point at 1.
          if (rsp_done) ptr_q <= grant_q[0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a real shared ALU instance.
// Expected responses are queued when stimulus is driven and popped by a
// monitor when a response handshake completes.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] alu_op1, alu_op2, alu_result;
  logic [3:0]    alu_ctrl;
  logic          alu_eq;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int          req;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic [31:0] data;
    logic        eq;
    logic        err;
  } vec_t;

  typedef struct {
    logic [1:0]  grant;
    logic [31:0] data;
    logic        eq;
    logic        err;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_eq     (alu_eq)
  );

  alu #(.DATA_WIDTH(DW)) u_alu (
    .op1    (alu_op1),
    .op2    (alu_op2),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .eq     (alu_eq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int r);
    return (r == 1) ? 2'b10 : 2'b01;
  endfunction

  // Response scoreboard: one pop per completed response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ((bus.rsp_valid & bus.rsp_ready) != 2'b00)) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_rsp", bus.rsp_valid, 2'b00);
      end else begin
        e = sb.pop_front();
        check("rsp_grant", bus.rsp_valid, e.grant);
        check("rsp_data", bus.rsp_data, e.data);
        check("rsp_eq", bus.rsp_eq, e.eq);
        check("rsp_err", bus.rsp_err, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, bus.req_ready, 2'b00);
    check({name, "_rsp_valid"}, bus.rsp_valid, 2'b00);
    check({name, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({name, "_rsp_eq_err"}, {bus.rsp_eq, bus.rsp_err}, 2'b00);
    check({name, "_alu_ops"}, {alu_op1, alu_op2}, 64'd0);
    check({name, "_alu_ctrl"}, alu_ctrl, 4'b0000);
  endtask

  task automatic do_reset(input string name);
    tick();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    check_reset_outputs(name);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
  endtask

  // Returns at the negedge of the accept cycle.
  task automatic wait_accept(input logic [1:0] exp, input string name, input int max_cyc,
                             output int at);
    bit got;
    got = 0;
    at = -1;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        got = 1;
        at = cyc;
        check({name, "_grant"}, bus.req_ready, exp);
      end else if (i < max_cyc - 1) begin
        tick();
      end
    end
    if (!got) check({name, "_accept_timeout"}, bus.req_ready, exp);
  endtask

  // Returns at the negedge of the first cycle with a response valid.
  task automatic wait_rsp(input logic [1:0] exp, input string name, input int max_cyc,
                          output int at);
    bit got;
    got = 0;
    at = -1;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        got = 1;
        at = cyc;
        check({name, "_rsp_valid"}, bus.rsp_valid, exp);
      end else if (i < max_cyc - 1) begin
        tick();
      end
    end
    if (!got) check({name, "_rsp_timeout"}, bus.rsp_valid, exp);
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    bus.req_op1[r]  = a;
    bus.req_op2[r]  = b;
    bus.req_ctrl[r] = c;
  endtask

  // Single-requester transaction with latency, EXEC-phase and payload-isolation checks.
  task automatic run_one(input vec_t v, input string name);
    int acc, rsp;
    logic legal;
    legal = (v.ctrl <= 4'd9);
    set_req(v.req, v.op1, v.op2, v.ctrl);
    bus.req_valid = onehot(v.req);
    sb.push_back('{onehot(v.req), v.data, v.eq, v.err});
    wait_accept(onehot(v.req), name, 4, acc);
    check({name, "_idle_alu"}, {alu_ctrl, alu_op1}, 36'd0);
    tick();
    bus.req_valid = 2'b00;
    set_req(v.req, ~v.op1, ~v.op2, 4'b0001);
    @(negedge clk);
    check({name, "_exec_ready"}, {bus.req_ready, bus.rsp_valid}, 4'b0000);
    check({name, "_exec_ctrl"}, alu_ctrl, legal ? v.ctrl : 4'b0000);
    check({name, "_exec_ops"}, {alu_op1, alu_op2}, legal ? {v.op1, v.op2} : 64'd0);
    tick();
    wait_rsp(onehot(v.req), name, 4, rsp);
    check({name, "_latency"}, rsp - acc, 2);
    tick();
  endtask

  initial begin
    int a0, a1, r0, prev;
    logic [1:0] g;

    vecs[0]  = '{0, 32'd5,        32'd7,  4'b0000, 32'd12,        1'b0, 1'b0};
    vecs[1]  = '{1, 32'd9,        32'd9,  4'b0001, 32'd0,         1'b1, 1'b0};
    vecs[2]  = '{0, 32'h0000F0F0, 32'h0000FF00, 4'b0010, 32'h0000F000, 1'b0, 1'b0};
    vecs[3]  = '{1, 32'h000000F0, 32'h0000000F, 4'b0011, 32'h000000FF, 1'b0, 1'b0};
    vecs[4]  = '{0, 32'd1,        32'd4,  4'b0100, 32'd16,        1'b0, 1'b0};
    vecs[5]  = '{1, 32'hFFFFFFFF, 32'd1,  4'b0101, 32'd1,         1'b0, 1'b0};
    vecs[6]  = '{0, 32'h80000000, 32'd4,  4'b0110, 32'h08000000,  1'b0, 1'b0};
    vecs[7]  = '{1, 32'h80000000, 32'd4,  4'b0111, 32'hF8000000,  1'b0, 1'b0};
    vecs[8]  = '{0, 32'd5,        32'd3,  4'b1000, 32'd1,         1'b0, 1'b0};
    vecs[9]  = '{1, 32'h000000FF, 32'h0000000F, 4'b1001, 32'h000000F0, 1'b0, 1'b0};
    vecs[10] = '{1, 32'd3,        32'd4,  4'b1100, 32'd0,         1'b0, 1'b1};
    vecs[11] = '{0, 32'd1,        32'd1,  4'b0000, 32'd2,         1'b1, 1'b0};
    vecs[12] = '{0, 32'd7,        32'd7,  4'b1111, 32'd0,         1'b0, 1'b1};
    vecs[13] = '{1, 32'hFFFFFFFF, 32'd1,  4'b0000, 32'd0,         1'b0, 1'b0};

    bus.req_valid = 2'b00;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_ctrl  = '0;
    bus.rsp_ready = 2'b11;

    do_reset("rst0");

    // Both valid straight after reset: requester 0 first, then requester 1.
    set_req(0, 32'd9, 32'd9, 4'b0001);
    set_req(1, 32'h000000F0, 32'h0000000F, 4'b0011);
    bus.req_valid = 2'b11;
    sb.push_back('{2'b01, 32'd0, 1'b1, 1'b0});
    sb.push_back('{2'b10, 32'h000000FF, 1'b0, 1'b0});
    wait_accept(2'b01, "both_first", 2, a0);
    tick();
    wait_accept(2'b10, "both_second", 6, a1);
    check("both_interval", a1 - a0, 3);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(2'b10, "both_rsp", 4, r0);
    tick();

    // Table of single-requester operations, including illegal codes.
    for (int i = 0; i < 14; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // Both held valid: strict alternation, accepts three cycles apart.
    do_reset("rst1");
    set_req(0, 32'd2, 32'd3, 4'b0000);
    set_req(1, 32'd10, 32'd4, 4'b0001);
    bus.req_valid = 2'b11;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      g = (k % 2 == 1) ? 2'b10 : 2'b01;
      sb.push_back('{g, (g == 2'b01) ? 32'd5 : 32'd6, 1'b0, 1'b0});
      wait_accept(g, $sformatf("rr%0d", k), 6, a0);
      if (k > 0) check($sformatf("rr%0d_interval", k), a0 - prev, 3);
      prev = a0;
      tick();
    end
    bus.req_valid = 2'b00;
    wait_rsp(2'b10, "rr_last", 4, r0);
    tick();

    // Response back-pressure, including a ready from the non-granted requester.
    do_reset("rst2");
    bus.rsp_ready = 2'b00;
    set_req(0, 32'd2, 32'd2, 4'b0000);
    bus.req_valid = 2'b01;
    sb.push_back('{2'b01, 32'd4, 1'b1, 1'b0});
    wait_accept(2'b01, "stall_acc", 2, a0);
    tick();
    set_req(1, 32'd1, 32'd2, 4'b0011);
    bus.req_valid = 2'b11;
    sb.push_back('{2'b10, 32'd3, 1'b0, 1'b0});
    wait_rsp(2'b01, "stall", 4, r0);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("stall%0d_hold", i), {bus.rsp_valid, bus.req_ready}, 4'b0100);
      check($sformatf("stall%0d_data", i), bus.rsp_data, 32'd4);
      tick();
      bus.rsp_ready = (i >= 4) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    tick();
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    check("stall_release_valid", bus.rsp_valid, 2'b01);
    tick();
    bus.rsp_ready = 2'b11;
    wait_accept(2'b10, "stall_next", 1, a1);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(2'b10, "stall_next", 4, r0);
    tick();

    // Reset during EXEC: transaction dropped, pointer back to requester 0.
    do_reset("rst3");
    set_req(0, 32'd3, 32'd5, 4'b0011);
    bus.req_valid = 2'b01;
    wait_accept(2'b01, "mid_acc", 2, a0);
    tick();
    set_req(1, 32'd1, 32'd1, 4'b0001);
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("mid_exec_ctrl", alu_ctrl, 4'b0011);
    check("mid_exec_op1", alu_op1, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(0, 32'd8, 32'd9, 4'b0000);
    sb.push_back('{2'b01, 32'd17, 1'b0, 1'b0});
    wait_accept(2'b01, "post_rst", 1, a0);
    check("post_rst_no_rsp", bus.rsp_valid, 2'b00);
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(2'b01, "post_rst", 4, r0);
    check("post_rst_latency", r0 - a0, 2);
    tick();

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
